// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and helpers for the pipeline control unit.
// The slot type holds the flags only; rd is kept beside it because its width is a parameter.
package pipe_ctrl_pkg;
   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;
   typedef struct packed {
      logic valid;
      logic we;
      logic is_load;
   } slot_t;
   localparam int FWD_RF = 0;
   function automatic int sel_w(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: decode-side request and stall/forward control bundle.
interface pipe_ctrl_if import pipe_ctrl_pkg::*; #(
   parameter int NSTAGES    = 4,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) ();
   localparam int SW = sel_w(NSTAGES);
   logic                  id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_is_load, id_halt;
   logic [REG_ADDR_W-1:0] id_rs1, id_rs2, id_rd;
   logic                  mem_stall, exe_flush;
   logic                  stall_if, stall_id, insert_nop, stall_exe, halted;
   logic [SW-1:0]         fwd_sel_rs1, fwd_sel_rs2, inflight;
   logic [CNT_W-1:0]      stall_cnt;
   modport master (
      output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_we, id_is_load,
             id_halt, mem_stall, exe_flush,
      input  stall_if, stall_id, insert_nop, stall_exe, fwd_sel_rs1, fwd_sel_rs2, inflight,
             halted, stall_cnt
   );
   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_we, id_is_load,
             id_halt, mem_stall, exe_flush,
      output stall_if, stall_id, insert_nop, stall_exe, fwd_sel_rs1, fwd_sel_rs2, inflight,
             halted, stall_cnt
   );
endinterface

// File: rtl/pipe_ctrl_sb.sv
// pipe_ctrl_sb: in-flight destination scoreboard, slot0 = EXE ... slot NSTAGES-1 = WB.
module pipe_ctrl_sb import pipe_ctrl_pkg::*; #(
   parameter int NSTAGES    = 4,
   parameter int REG_ADDR_W = 5
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         hold_i,
   input  logic                         push_i,
   input  logic [REG_ADDR_W-1:0]        rd_i,
   input  logic                         we_i,
   input  logic                         load_i,
   input  logic [REG_ADDR_W-1:0]        rs1_i,
   input  logic [REG_ADDR_W-1:0]        rs2_i,
   input  logic                         rs1_used_i,
   input  logic                         rs2_used_i,
   output logic [NSTAGES-1:0]           m1_o,
   output logic [NSTAGES-1:0]           m2_o,
   output logic                         load0_o,
   output logic [sel_w(NSTAGES)-1:0]    cnt_o
);
   localparam int SW = sel_w(NSTAGES);
   slot_t [NSTAGES-1:0]                  slot_q, slot_d;
   logic  [NSTAGES-1:0][REG_ADDR_W-1:0]  rd_q, rd_d;
   always_comb begin
      slot_d = slot_q;
      rd_d   = rd_q;
      if (!hold_i) begin
         for (int k = NSTAGES - 1; k > 0; k--) begin
            slot_d[k] = slot_q[k-1];
            rd_d[k]   = rd_q[k-1];
         end
         slot_d[0] = '{valid: push_i, we: push_i & we_i, is_load: push_i & load_i};
         rd_d[0]   = rd_i;
      end
   end
   always_ff @(posedge clk) begin
      slot_q <= reset ? '0 : slot_d;
      rd_q   <= reset ? '0 : rd_d;
   end
   always_comb begin
      m1_o  = '0;
      m2_o  = '0;
      cnt_o = '0;
      for (int k = 0; k < NSTAGES; k++) begin
         m1_o[k] = slot_q[k].valid & slot_q[k].we & (|rd_q[k]) & (rd_q[k] == rs1_i) & rs1_used_i;
         m2_o[k] = slot_q[k].valid & slot_q[k].we & (|rd_q[k]) & (rd_q[k] == rs2_i) & rs2_used_i;
         cnt_o   = cnt_o + SW'(slot_q[k].valid);
      end
   end
   assign load0_o = slot_q[0].valid & slot_q[0].is_load;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard/forward control, halt drain FSM and stall counter for the in-order core.
module pipe_ctrl import pipe_ctrl_pkg::*; #(
   parameter int NSTAGES    = 4,
   parameter int REG_ADDR_W = 5,
   parameter int FORWARD_EN = 0,
   parameter int CNT_W      = 16
) (
   input logic        clk,
   input logic        reset,
   pipe_ctrl_if.slave bus
);
   localparam int SW = sel_w(NSTAGES);
   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [NSTAGES-1:0] m1, m2;
   logic [SW-1:0]      inflight, fsel1, fsel2;
   logic               load0, hazard, issue, stall;
   pipe_ctrl_sb #(.NSTAGES(NSTAGES), .REG_ADDR_W(REG_ADDR_W)) u_sb (
      .clk        (clk),
      .reset      (reset),
      .hold_i     (bus.mem_stall),
      .push_i     (issue),
      .rd_i       (bus.id_rd),
      .we_i       (bus.id_rd_we),
      .load_i     (bus.id_is_load),
      .rs1_i      (bus.id_rs1),
      .rs2_i      (bus.id_rs2),
      .rs1_used_i (bus.id_rs1_used),
      .rs2_used_i (bus.id_rs2_used),
      .m1_o       (m1),
      .m2_o       (m2),
      .load0_o    (load0),
      .cnt_o      (inflight)
   );
   assign hazard = bus.id_valid & ((FORWARD_EN != 0) ? (load0 & (m1[0] | m2[0])) : (|{m1, m2}));
   assign issue  = bus.id_valid & ~hazard & ~bus.exe_flush & ~bus.mem_stall & (state_q == RUN);
   // youngest slot wins: scan oldest to youngest so the lowest k overwrites
   always_comb begin
      fsel1 = SW'(FWD_RF);
      fsel2 = SW'(FWD_RF);
      for (int k = NSTAGES - 1; k >= 0; k--) begin
         fsel1 = m1[k] ? SW'(k + 1) : fsel1;
         fsel2 = m2[k] ? SW'(k + 1) : fsel2;
      end
   end
   always_ff @(posedge clk) begin
      state_q <= reset ? RUN : state_d;
      cnt_q   <= reset ? '0 : cnt_d;
   end
   always_comb begin
      state_d = (state_q == RUN && issue && bus.id_halt) ? DRAIN :
                (state_q == DRAIN && inflight == '0)     ? HALTED : state_q;
   end
   assign stall = bus.mem_stall | (hazard & ~bus.exe_flush) | (state_q != RUN);
   assign cnt_d = (stall && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   always_comb begin
      bus.stall_if    = ~reset & stall;
      bus.stall_id    = ~reset & bus.mem_stall;
      bus.stall_exe   = ~reset & bus.mem_stall;
      bus.insert_nop  = ~reset & ~bus.exe_flush & (hazard | (state_q == DRAIN));
      bus.fwd_sel_rs1 = (reset || FORWARD_EN == 0) ? SW'(FWD_RF) : fsel1;
      bus.fwd_sel_rs2 = (reset || FORWARD_EN == 0) ? SW'(FWD_RF) : fsel2;
      bus.inflight    = reset ? '0 : inflight;
      bus.halted      = ~reset & (state_q == HALTED);
      bus.stall_cnt   = reset ? '0 : cnt_q;
   end
endmodule
